iterative_alu: RTL and testbench
================================

# iterative_alu

Parametrised, handshaked ALU that supersedes the fixed 16-bit combinational ALU in the CPU datapath. It accepts an opcode and two `WIDTH`-bit operands over a valid/ready interface and registers the result plus status flags. It adds shifts, a Zero flag, illegal-opcode detection and an optional iterative shift-add multiplier. It sits between register-file read and write-back; the flags output feeds the status register.

## Interface
- `WIDTH`, 16: operand/result width; legal values are 4..64, powers of two only.
- `SHW`, `$clog2(WIDTH)`: shift-amount width; derived, do not override.
- `Clock` in 1: single clock; all state changes on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `InValid` in 1: Opcode/OperandA/OperandB are valid.
- `InReady` out 1: block can accept; equals 1 only in IDLE.
- `Opcode` in 5: operation select.
- `OperandA` in WIDTH: first operand.
- `OperandB` in WIDTH: second operand, or shift amount (bits `[SHW-1:0]`).
- `OutValid` out 1: Result and flags valid.
- `OutReady` in 1: consumer accepts result.
- `Result` out WIDTH: registered result.
- `Carry`, `Negative`, `Overflow`, `Zero`, `Illegal` out 1 each: registered flags.

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT (~A)
  - 6 SHL
  - 7 SHR (logical)
  - 8 SRA (arithmetic)
  - 9 MUL (unsigned, low half)
  - 10..31 illegal
- FSM states:
  - IDLE: `InReady`=1. On `InValid`, capture the inputs. Non-MUL goes to DONE; MUL goes to BUSY.
  - BUSY: one shift-add step per cycle for `WIDTH` cycles, then DONE.
  - DONE: `OutValid`=1. Stay until `OutReady`=1, then go to IDLE.
- Arithmetic runs at WIDTH+1 bits.
  - ADD: Carry = carry-out.
  - SUB: computed as A+~B+1; Carry = borrow (= NOT carry-out).
  - Overflow = signed overflow for ADD/SUB, 0 for all other ops.
- Logic ops: Carry=0.
- Shifts:
  - Amount n = `OperandB[SHW-1:0]`; upper bits of B are ignored.
  - Carry = last bit shifted out; 0 when n=0.
  - SRA replicates the MSB.
- MUL:
  - Result = low `WIDTH` bits of A*B.
  - Carry = 1 iff the high half is nonzero.
- All ops:
  - Negative = `Result[WIDTH-1]`.
  - Zero = (Result==0).
- Illegal opcode: Result=0, Zero=1, Illegal=1, other flags 0. Latency is the same as a single-cycle op.
- `Result` and the flags hold their value from DONE until the next result is registered.

## Timing
- Reset values: `InReady`=1 (state IDLE); `OutValid`=0; `Result`=0; all flags 0.
- Reset while BUSY or DONE aborts the operation. The next cycle is IDLE with all outputs at reset values, and the result is discarded.
- Non-MUL latency: accept at edge N, `OutValid`=1 from edge N+1.
- MUL latency: `OutValid`=1 at edge N+`WIDTH`+1.
- Throughput: at most one op every 2 cycles, because `InReady`=0 in DONE.
- `OutReady` is don't-care while `OutValid`=0.
- `OutValid` with `OutReady` in the same cycle: transfer completes, next state IDLE.
- `InValid` while `InReady`=0 is ignored; the producer must hold it.

## Configuration
- Macro `ITERATIVE_ALU_MUL_EN`.
- Defined: the multiplier and BUSY state are compiled in.
- Undefined:
  - Opcode 9 is treated as illegal.
  - BUSY is unreachable and the multiplier logic is absent.
  - All ops have latency 1.

## Structure
- Package `alu_pkg` holds:
  - `alu_op_t` (5-bit enum of opcodes 0..9);
  - `alu_state_t` (IDLE, BUSY, DONE);
  - constants `ALU_OP_LAST`=9 and `ALU_OP_ILLEGAL_MIN`=10.
- Sub-module `shift_add_multiplier`, instantiated under the macro:
  - inputs `Start`, A, B; outputs `Done` and a 2*`WIDTH` product;
  - one partial product per cycle.

## Test plan
- ADD 0xFFFF+0x0001 (WIDTH=16) -> Result 0x0000, Carry=1, Zero=1, Overflow=0, at 1-cycle latency.
- SUB 0x8000−0x0001 -> Result 0x7FFF, Overflow=1, Carry=0, Negative=0. SUB 0x0001−0x0002 -> 0xFFFF, Carry=1, Negative=1.
- Shifts with A=0x8001:
  - SHL, B=0x0001 -> 0x0002, Carry=1;
  - SRA, B=0x0004 -> 0xF800, Carry=0;
  - SHR, B=0x0010 (n=0) -> 0x8001, Carry=0.
- MUL with the macro defined: 0x0100*0x0100 -> Result 0x0000, Carry=1, `OutValid` at N+17. Without the macro: Illegal=1 at N+1.
- Backpressure: hold `OutReady`=0 for 5 cycles -> `OutValid`/Result stable and `InReady`=0 throughout. Raise `OutReady` -> IDLE the next cycle.
- Assert `Reset` mid-MUL (BUSY cycle 8) -> IDLE the next cycle, all outputs 0. Opcode 31 -> Illegal=1, Zero=1, Result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the iterative ALU.
//   alu_op_t    - 5-bit opcode encoding (0..9 legal, 10..31 illegal)
//   alu_state_t - control FSM states
//   alu_flags_t - registered status flags driven to the status register
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_XOR = 5'd4,
    ALU_NOT = 5'd5,
    ALU_SHL = 5'd6,
    ALU_SHR = 5'd7,
    ALU_SRA = 5'd8,
    ALU_MUL = 5'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  typedef struct packed {
    logic carry;
    logic negative;
    logic overflow;
    logic zero;
    logic illegal;
  } alu_flags_t;

  localparam logic [4:0] ALU_OP_LAST        = 5'd9;
  localparam logic [4:0] ALU_OP_ILLEGAL_MIN = 5'd10;

endpackage

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: unsigned WIDTH x WIDTH multiplier, one partial product
// per cycle. Start loads the operands and already accumulates the first
// partial product, so Done rises WIDTH-1 cycles after the Start edge and the
// full 2*WIDTH product is on Product while Done is high.
//   Clock, Reset  - clock, synchronous active-high reset
//   Start         - load A/B and begin (ignored state is overwritten)
//   A, B          - operands
//   Done          - Product is complete
//   Product       - 2*WIDTH-bit product
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (Start) begin
      acc    <= B[0] ? {{WIDTH{1'b0}}, A} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, A, 1'b0};
      mplier <= B >> 1;
      cnt    <= CW'(WIDTH - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign Done    = busy && (cnt == '0);
  assign Product = acc;

endmodule

// File: rtl/iterative_alu.sv
// iterative_alu: handshaked ALU with registered result and status flags.
// Single-cycle ops are computed combinationally and registered on the accept
// edge; MUL (only when ITERATIVE_ALU_MUL_EN is defined) runs through the
// shift-add multiplier in BUSY. Without the macro opcode 9 is illegal.
//   Clock, Reset        - clock, synchronous active-high reset
//   InValid / InReady   - request handshake (InReady only in IDLE)
//   Opcode, OperandA/B  - operation and operands (B[SHW-1:0] = shift amount)
//   OutValid / OutReady - result handshake (OutValid only in DONE)
//   Result + flags      - registered, held until the next result loads
module iterative_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [4:0]       Opcode,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Negative,
  output logic             Overflow,
  output logic             Zero,
  output logic             Illegal
);

  alu_state_t state_q, state_d;
  logic       load_alu;

  logic [WIDTH-1:0] alu_res, res_q;
  alu_flags_t       alu_flags, flags_q;

  logic [WIDTH:0]   sum, dif, shl_x, shr_x, sra_x;
  logic [SHW-1:0]   n;
  logic             c, v, ill;

  // ---------------- single-cycle datapath ----------------
  assign n = OperandB[SHW-1:0];

  always_comb begin
    sum   = {1'b0, OperandA} + {1'b0, OperandB};
    dif   = {1'b0, OperandA} + {1'b0, ~OperandB} + {{WIDTH{1'b0}}, 1'b1};
    // Shifts carry one extra bit so the last bit shifted out lands in it
    // (top bit for SHL, bottom bit for SHR/SRA); n=0 leaves it 0.
    shl_x = {1'b0, OperandA} << n;
    shr_x = {OperandA, 1'b0} >> n;
    sra_x = $signed({OperandA, 1'b0}) >>> n;
    alu_res = '0;
    c       = 1'b0;
    v       = 1'b0;
    ill     = 1'b0;
    case (alu_op_t'(Opcode))
      ALU_ADD: begin
        alu_res = sum[WIDTH-1:0];
        c       = sum[WIDTH];
        v       = (OperandA[WIDTH-1] == OperandB[WIDTH-1]) &&
                  (sum[WIDTH-1] != OperandA[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = dif[WIDTH-1:0];
        c       = ~dif[WIDTH];   // borrow
        v       = (OperandA[WIDTH-1] != OperandB[WIDTH-1]) &&
                  (dif[WIDTH-1] != OperandA[WIDTH-1]);
      end
      ALU_AND: alu_res = OperandA & OperandB;
      ALU_OR:  alu_res = OperandA | OperandB;
      ALU_XOR: alu_res = OperandA ^ OperandB;
      ALU_NOT: alu_res = ~OperandA;
      ALU_SHL: begin alu_res = shl_x[WIDTH-1:0]; c = shl_x[WIDTH]; end
      ALU_SHR: begin alu_res = shr_x[WIDTH:1];   c = shr_x[0];     end
      ALU_SRA: begin alu_res = sra_x[WIDTH:1];   c = sra_x[0];     end
`ifdef ITERATIVE_ALU_MUL_EN
      ALU_MUL: ;  // result comes from the multiplier, never loaded from here
`endif
      default: ill = 1'b1;
    endcase
    alu_flags = '{carry: c, negative: alu_res[WIDTH-1], overflow: v,
                  zero: (alu_res == '0), illegal: ill};
  end

`ifdef ITERATIVE_ALU_MUL_EN
  // ---------------- iterative multiplier ----------------
  logic               mul_start, mul_done, load_mul;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_res;
  alu_flags_t         mul_flags;

  shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (mul_start),
    .A       (OperandA),
    .B       (OperandB),
    .Done    (mul_done),
    .Product (mul_prod)
  );

  assign mul_res   = mul_prod[WIDTH-1:0];
  assign mul_flags = '{carry: |mul_prod[2*WIDTH-1:WIDTH],
                       negative: mul_res[WIDTH-1], overflow: 1'b0,
                       zero: (mul_res == '0), illegal: 1'b0};
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_alu = 1'b0;
`ifdef ITERATIVE_ALU_MUL_EN
    mul_start = 1'b0;
    load_mul  = 1'b0;
`endif
    case (state_q)
      IDLE: if (InValid) begin
`ifdef ITERATIVE_ALU_MUL_EN
        if (Opcode == ALU_MUL) begin
          mul_start = 1'b1;
          state_d   = BUSY;
        end else begin
          load_alu = 1'b1;
          state_d  = DONE;
        end
`else
        load_alu = 1'b1;
        state_d  = DONE;
`endif
      end
`ifdef ITERATIVE_ALU_MUL_EN
      BUSY: if (mul_done) begin
        load_mul = 1'b1;
        state_d  = DONE;
      end
`endif
      DONE:    if (OutReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- result / flag registers ----------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      res_q   <= '0;
      flags_q <= '0;
    end else if (load_alu) begin
      res_q   <= alu_res;
      flags_q <= alu_flags;
    end
`ifdef ITERATIVE_ALU_MUL_EN
    else if (load_mul) begin
      res_q   <= mul_res;
      flags_q <= mul_flags;
    end
`endif
  end

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign Result   = res_q;
  assign Carry    = flags_q.carry;
  assign Negative = flags_q.negative;
  assign Overflow = flags_q.overflow;
  assign Zero     = flags_q.zero;
  assign Illegal  = flags_q.illegal;

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: table-driven self-checking bench for iterative_alu
// (WIDTH=16). Expected records are queued when an op is driven and popped
// when OutValid rises; hand sequences cover backpressure and reset aborts.
module tb_iterative_alu;

  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         Reset, InValid, OutReady;
  logic [4:0]   Opcode;
  logic [W-1:0] OperandA, OperandB;
  logic         InReady, OutValid;
  logic [W-1:0] Result;
  logic         Carry, Negative, Overflow, Zero, Illegal;

  iterative_alu #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Opcode(Opcode), .OperandA(OperandA), .OperandB(OperandB),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
    .Carry(Carry), .Negative(Negative), .Overflow(Overflow), .Zero(Zero),
    .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a, b, res;
    logic [4:0]   flg;   // {carry, negative, overflow, zero, illegal}
    int           lat;   // edges from presentation to OutValid
  } vec_t;

  vec_t vt[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [4:0] op, logic [W-1:0] a, logic [W-1:0] b,
                              logic [W-1:0] res, logic c, logic n, logic v,
                              logic z, logic ill, int lat);
    vec_t r;
    r.op = op; r.a = a; r.b = b; r.res = res;
    r.flg = {c, n, v, z, ill}; r.lat = lat;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {Carry, Negative, Overflow, Zero, Illegal};
  endfunction

  // Drive one op, wait for its result, compare against the scoreboard, stall
  // for `hold` cycles with OutReady low, then complete the handshake.
  task automatic run_op(input vec_t v, input string tag, input int hold);
    int   lat;
    vec_t e;
    sb.push_back(v);
    @(negedge Clock);
    chk({tag, "_in_ready"}, InReady, 1);
    InValid = 1'b1; Opcode = v.op; OperandA = v.a; OperandB = v.b;
    lat = 0;
    do begin
      @(posedge Clock); lat++; #1;
      if (lat == 1) InValid = 1'b0;
      if (v.lat > 2 && lat == 5) chk({tag, "_busy_in_ready"}, InReady, 0);
    end while (!OutValid && lat < 100);
    e = sb.pop_front();
    if (!OutValid) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_out_valid expected=out_valid", tag);
      return;
    end
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_result"},  Result, e.res);
    chk({tag, "_flags"},   flags_now(), e.flg);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      InValid = 1'b1; Opcode = 5'd1; OperandA = 16'h0009; OperandB = 16'h0001;
      @(posedge Clock); #1;
      chk($sformatf("%s_hold%0d_out_valid", tag, i), OutValid, 1);
      chk($sformatf("%s_hold%0d_in_ready", tag, i),  InReady, 0);
      chk($sformatf("%s_hold%0d_result", tag, i),    Result, e.res);
    end
    @(negedge Clock);
    InValid = 1'b0; OutReady = 1'b1;
    @(posedge Clock); #1;
    OutReady = 1'b0;
    chk({tag, "_drain_out_valid"}, OutValid, 0);
    chk({tag, "_drain_in_ready"},  InReady, 1);
    chk({tag, "_drain_result_held"}, Result, e.res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        op     a        b        res      C N V Z I lat
    vt.push_back(mk(5'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0, 1, 0, 1));
    vt.push_back(mk(5'd1, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1, 0, 0, 1));
    vt.push_back(mk(5'd1, 16'h0001, 16'h0002, 16'hFFFF, 1, 1, 0, 0, 0, 1));
    vt.push_back(mk(5'd6, 16'h8001, 16'h0001, 16'h0002, 1, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'd8, 16'h8001, 16'h0004, 16'hF800, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(5'd7, 16'h8001, 16'h0010, 16'h8001, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(5'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'd3, 16'hF000, 16'h000F, 16'hF00F, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(5'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 0, 0, 0, 1, 0, 1));
    vt.push_back(mk(5'd5, 16'h00FF, 16'h1234, 16'hFF00, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(5'd0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 1, 0, 0, 1));
    vt.push_back(mk(5'd7, 16'h8001, 16'h0001, 16'h4000, 1, 0, 0, 0, 0, 1));
    vt.push_back(mk(5'd8, 16'h8000, 16'h000F, 16'hFFFF, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(5'd6, 16'h0001, 16'h000F, 16'h8000, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(5'd31, 16'h1234, 16'h5678, 16'h0000, 0, 0, 0, 1, 1, 1));
    vt.push_back(mk(5'd10, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 0, 1, 1, 1));
`ifdef ITERATIVE_ALU_MUL_EN
    vt.push_back(mk(5'd9, 16'h0100, 16'h0100, 16'h0000, 1, 0, 0, 1, 0, 17));
    vt.push_back(mk(5'd9, 16'h0003, 16'h0005, 16'h000F, 0, 0, 0, 0, 0, 17));
    vt.push_back(mk(5'd9, 16'hFFFF, 16'hFFFF, 16'h0001, 1, 0, 0, 0, 0, 17));
`else
    vt.push_back(mk(5'd9, 16'h0100, 16'h0100, 16'h0000, 0, 0, 0, 1, 1, 1));
`endif

    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    Opcode = '0; OperandA = '0; OperandB = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_in_ready",  InReady, 1);
    chk("reset_out_valid", OutValid, 0);
    chk("reset_result",    Result, 0);
    chk("reset_flags",     flags_now(), 0);
    @(negedge Clock); Reset = 1'b0;

    for (int i = 0; i < vt.size(); i++)
      run_op(vt[i], $sformatf("vec%0d", i), 0);

    // Backpressure: result held 5 cycles while a second request is ignored.
    run_op(mk(5'd0, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0, 0, 1), "bp", 5);

    // Reset aborts an in-flight op; Result still holds 0x0003 before it.
    @(negedge Clock);
    InValid = 1'b1; OperandA = 16'h0100; OperandB = 16'h0100;
`ifdef ITERATIVE_ALU_MUL_EN
    Opcode = 5'd9;
    @(posedge Clock); #1; InValid = 1'b0;
    repeat (7) @(posedge Clock);   // now in BUSY cycle 8
    #1; chk("abort_busy_out_valid", OutValid, 0);
`else
    Opcode = 5'd0;
    @(posedge Clock); #1; InValid = 1'b0;
    chk("abort_done_out_valid", OutValid, 1);
`endif
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;
    chk("abort_in_ready",  InReady, 1);
    chk("abort_out_valid", OutValid, 0);
    chk("abort_result",    Result, 0);
    chk("abort_flags",     flags_now(), 0);
    @(negedge Clock); Reset = 1'b0;

    // Recovery after the abort.
    run_op(mk(5'd31, 16'hBEEF, 16'h0001, 16'h0000, 0, 0, 0, 1, 1, 1), "post_rst_ill", 0);
    run_op(mk(5'd1, 16'h0005, 16'h0005, 16'h0000, 0, 0, 0, 1, 0, 1), "post_rst_sub", 0);
`ifdef ITERATIVE_ALU_MUL_EN
    run_op(mk(5'd9, 16'h0007, 16'h0009, 16'h003F, 0, 0, 0, 0, 0, 17), "post_rst_mul", 0);
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
